// File: rtl/regfile_access_master.sv
// Purpose: command-driven burst initiator for one register file instance.
//   Accepts read/write burst commands (valid/ready), drives the register file
//   write/read strobes and addresses, and returns read data on a valid/ready stream.
// Latency: write beats commit at the edge they are accepted (1 beat/cycle);
//   each read beat takes one issue cycle plus at least one response cycle.
// Backpressure: cmd_ready is low for the whole burst; wr_ready is high only while
//   writing; a read beat holds rd_data/rd_last stable until rd_ready.
//
// Ports:
//   clk, reset_n                       clock and async active-low reset
//   cmd_valid/cmd_ready/cmd_write/
//     cmd_addr/cmd_len                 burst command (cmd_len = beats - 1)
//   wr_valid/wr_ready/wr_data          write-data beats
//   rd_valid/rd_ready/rd_data/rd_last  read responses
//   rf_write/rf_wr_addr/rf_in_data     register file write port
//   rf_read/rf_rd_addr/rf_out_data     register file read port (combinational data)
module regfile_access_master #(
  parameter int WORD_WIDTH = 32,
  parameter int LENGTH     = 128,
  parameter int LEN_W      = 8,
  localparam int AW        = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rf_write,
  output logic [AW-1:0]         rf_wr_addr,
  output logic [WORD_WIDTH-1:0] rf_in_data,
  output logic                  rf_read,
  output logic [AW-1:0]         rf_rd_addr,
  input  logic [WORD_WIDTH-1:0] rf_out_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]        remain_q, remain_d;
  logic [WORD_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_last_q, rd_last_d;
  logic [AW-1:0]           addr_next;

  // Explicit wrap so non-power-of-2 depths roll over at the last word.
  assign addr_next = (cur_addr_q == AW'(LENGTH - 1)) ? '0 : cur_addr_q + AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rf_write   = 1'b0;
    rf_wr_addr = '0;
    rf_in_data = '0;
    rf_read    = 1'b0;
    rf_rd_addr = '0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          remain_d   = cmd_len;
          state_d    = cmd_write ? WR : RD_ISSUE;
        end
      end

      WR: begin
        wr_ready   = 1'b1;
        // Strobe follows wr_valid directly so the word lands on the accepting edge.
        rf_write   = wr_valid;
        rf_wr_addr = cur_addr_q;
        rf_in_data = wr_data;
        if (wr_valid) begin
          if (remain_q == '0) begin
            state_d = IDLE;
          end else begin
            remain_d   = remain_q - LEN_W'(1);
            cur_addr_d = addr_next;
          end
        end
      end

      RD_ISSUE: begin
        rf_read    = 1'b1;
        rf_rd_addr = cur_addr_q;
        rd_data_d  = rf_out_data;
        rd_last_d  = (remain_q == '0);
        state_d    = RD_RESP;
      end

      RD_RESP: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (rd_last_q) begin
            state_d = IDLE;
          end else begin
            remain_d   = remain_q - LEN_W'(1);
            cur_addr_d = addr_next;
            state_d    = RD_ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_data = rd_data_q;
  assign rd_last = rd_last_q;

endmodule
